// File: rtl/exec_pkg.sv
// rtl/exec_pkg.sv - shared opcodes, select codes and md FSM state for the execute stage
package exec_pkg;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   localparam logic MD_MULTU = 1'b0;
   localparam logic MD_DIVU  = 1'b1;

   localparam logic [1:0] MF_ALU = 2'b00;
   localparam logic [1:0] MF_HI  = 2'b01;
   localparam logic [1:0] MF_LO  = 2'b10;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_RUN  = 2'd1,
      MD_DONE = 2'd2
   } md_state_t;

endpackage

// File: rtl/md_unit.sv
// rtl/md_unit.sv - iterative unsigned multiply/divide with HI/LO registers
module md_unit
   import exec_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic             op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o,
   output logic             busy_o
);

   localparam int CNTW = $clog2(WIDTH);

   md_state_t          state_q;
   logic               op_q;
   logic [WIDTH-1:0]   b_q;
   logic [CNTW-1:0]    cnt_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [2*WIDTH-1:0] acc_d;
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_part;
   logic [WIDTH:0]     div_trial;

   // acc holds {upper, lower}: product/multiplier for MULTU, remainder/quotient for DIVU
   always_comb begin
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? b_q : {WIDTH{1'b0}})};
      div_part  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      div_trial = div_part - {1'b0, b_q};
      if (op_q == MD_MULTU) begin
         acc_d = {mul_sum, acc_q[WIDTH-1:1]};
      end else if (div_trial[WIDTH]) begin
         acc_d = {div_part[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end else begin
         acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= MD_IDLE;
         op_q    <= MD_MULTU;
         b_q     <= '0;
         cnt_q   <= '0;
         acc_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         case (state_q)
            MD_IDLE: begin
               if (start_i) begin
                  op_q    <= op_i;
                  b_q     <= b_i;
                  acc_q   <= {{WIDTH{1'b0}}, a_i};
                  cnt_q   <= '0;
                  state_q <= MD_RUN;
               end
            end
            MD_RUN: begin
               acc_q <= acc_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CNTW'(WIDTH - 1)) begin
                  state_q <= MD_DONE;
               end
            end
            MD_DONE: begin
               hi_q    <= acc_q[2*WIDTH-1:WIDTH];
               lo_q    <= acc_q[WIDTH-1:0];
               state_q <= MD_IDLE;
            end
            default: state_q <= MD_IDLE;
         endcase
      end
   end

   assign hi_o   = hi_q;
   assign lo_o   = lo_q;
   assign busy_o = (state_q != MD_IDLE);

endmodule

// File: rtl/execute_stage_md.sv
// rtl/execute_stage_md.sv - MiniMIPS execute stage: forwarding, ALU, HI/LO moves, E/M register
module execute_stage_md
   import exec_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int REGW  = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             valid_e,
   input  logic             alu_src_e,
   input  logic             reg_dst_e,
   input  logic [1:0]       forward_a_e,
   input  logic [1:0]       forward_b_e,
   input  logic [2:0]       alu_control_e,
   input  logic             md_start_e,
   input  logic             md_op_e,
   input  logic [1:0]       mf_sel_e,
   input  logic [WIDTH-1:0] rd1_e,
   input  logic [WIDTH-1:0] rd2_e,
   input  logic [WIDTH-1:0] sign_imm_e,
   input  logic [WIDTH-1:0] result_w,
   input  logic [WIDTH-1:0] alu_out_m_fb,
   input  logic [REGW-1:0]  rt_e,
   input  logic [REGW-1:0]  rd_e,
   output logic             valid_m,
   output logic [WIDTH-1:0] alu_out_m,
   output logic [WIDTH-1:0] write_data_m,
   output logic [REGW-1:0]  write_reg_m,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o,
   output logic             md_busy,
   output logic             stall_e
);

   logic [WIDTH-1:0] src_a;
   logic [WIDTH-1:0] fwd_b;
   logic [WIDTH-1:0] src_b;
   logic [WIDTH-1:0] alu_res;
   logic [WIDTH-1:0] result_e;
   logic [REGW-1:0]  write_reg_e;
   logic             md_start_ok;

   logic             valid_m_q, valid_m_d;
   logic [WIDTH-1:0] alu_out_m_q, alu_out_m_d;
   logic [WIDTH-1:0] write_data_m_q, write_data_m_d;
   logic [REGW-1:0]  write_reg_m_q, write_reg_m_d;

   always_comb begin
      case (forward_a_e)
         FWD_WB:  src_a = result_w;
         FWD_MEM: src_a = alu_out_m_fb;
         default: src_a = rd1_e;
      endcase
      case (forward_b_e)
         FWD_WB:  fwd_b = result_w;
         FWD_MEM: fwd_b = alu_out_m_fb;
         default: fwd_b = rd2_e;
      endcase
      src_b = alu_src_e ? sign_imm_e : fwd_b;
   end

   always_comb begin
      case (alu_control_e)
         ALU_AND: alu_res = src_a & src_b;
         ALU_OR:  alu_res = src_a | src_b;
         ALU_ADD: alu_res = src_a + src_b;
         ALU_SUB: alu_res = src_a - src_b;
         ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
         default: alu_res = '0;
      endcase
      case (mf_sel_e)
         MF_HI:   result_e = hi_o;
         MF_LO:   result_e = lo_o;
         default: result_e = alu_res;
      endcase
      write_reg_e = reg_dst_e ? rd_e : rt_e;
   end

   // Anything that reads HI/LO or needs the unit must wait until it is idle
   assign stall_e     = valid_e & md_busy & (md_start_e | (mf_sel_e == MF_HI) | (mf_sel_e == MF_LO));
   assign md_start_ok = valid_e & md_start_e & ~stall_e;

   md_unit #(
      .WIDTH (WIDTH)
   ) u_md_unit (
      .clk     (clk),
      .rst_n   (rst_n),
      .start_i (md_start_ok),
      .op_i    (md_op_e),
      .a_i     (src_a),
      .b_i     (fwd_b),
      .hi_o    (hi_o),
      .lo_o    (lo_o),
      .busy_o  (md_busy)
   );

   always_comb begin
      valid_m_d      = 1'b0;
      alu_out_m_d    = alu_out_m_q;
      write_data_m_d = write_data_m_q;
      write_reg_m_d  = write_reg_m_q;
      if (!stall_e) begin
         valid_m_d      = valid_e;
         alu_out_m_d    = result_e;
         write_data_m_d = fwd_b;
         write_reg_m_d  = write_reg_e;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_m_q      <= 1'b0;
         alu_out_m_q    <= '0;
         write_data_m_q <= '0;
         write_reg_m_q  <= '0;
      end else begin
         valid_m_q      <= valid_m_d;
         alu_out_m_q    <= alu_out_m_d;
         write_data_m_q <= write_data_m_d;
         write_reg_m_q  <= write_reg_m_d;
      end
   end

   assign valid_m      = valid_m_q;
   assign alu_out_m    = alu_out_m_q;
   assign write_data_m = write_data_m_q;
   assign write_reg_m  = write_reg_m_q;

endmodule

// File: tb/tb_execute_stage_md.sv
// tb/tb_execute_stage_md.sv - scoreboard bench for execute_stage_md
module tb_execute_stage_md;

   localparam int WIDTH = 32;
   localparam int REGW  = 5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst_n, valid_e, alu_src_e, reg_dst_e, md_start_e, md_op_e;
   logic [1:0]       forward_a_e, forward_b_e, mf_sel_e;
   logic [2:0]       alu_control_e;
   logic [WIDTH-1:0] rd1_e, rd2_e, sign_imm_e, result_w, alu_out_m_fb;
   logic [REGW-1:0]  rt_e, rd_e;
   logic             valid_m, md_busy, stall_e;
   logic [WIDTH-1:0] alu_out_m, write_data_m, hi_o, lo_o;
   logic [REGW-1:0]  write_reg_m;

   typedef struct packed {
      logic             v;
      logic [WIDTH-1:0] alu;
      logic [WIDTH-1:0] wd;
      logic [REGW-1:0]  wr;
   } m_t;

   typedef struct packed {
      logic             v;
      logic [2:0]       ctrl;
      logic [1:0]       fa;
      logic [1:0]       fb;
      logic             asrc;
      logic             rdst;
      logic [WIDTH-1:0] rd1;
      logic [WIDTH-1:0] rd2;
      logic [WIDTH-1:0] imm;
      logic [WIDTH-1:0] resw;
      logic [WIDTH-1:0] mfb;
      logic [REGW-1:0]  rt;
      logic [REGW-1:0]  rd;
      logic [WIDTH-1:0] exp_alu;
      logic [WIDTH-1:0] exp_wd;
      logic [REGW-1:0]  exp_wr;
   } row_t;

   m_t exp_q[$];
   int checks   = 0;
   int failures = 0;

   execute_stage_md #(.WIDTH(WIDTH), .REGW(REGW)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .valid_e       (valid_e),
      .alu_src_e     (alu_src_e),
      .reg_dst_e     (reg_dst_e),
      .forward_a_e   (forward_a_e),
      .forward_b_e   (forward_b_e),
      .alu_control_e (alu_control_e),
      .md_start_e    (md_start_e),
      .md_op_e       (md_op_e),
      .mf_sel_e      (mf_sel_e),
      .rd1_e         (rd1_e),
      .rd2_e         (rd2_e),
      .sign_imm_e    (sign_imm_e),
      .result_w      (result_w),
      .alu_out_m_fb  (alu_out_m_fb),
      .rt_e          (rt_e),
      .rd_e          (rd_e),
      .valid_m       (valid_m),
      .alu_out_m     (alu_out_m),
      .write_data_m  (write_data_m),
      .write_reg_m   (write_reg_m),
      .hi_o          (hi_o),
      .lo_o          (lo_o),
      .md_busy       (md_busy),
      .stall_e       (stall_e)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      valid_e = 1'b0; alu_src_e = 1'b0; reg_dst_e = 1'b0;
      md_start_e = 1'b0; md_op_e = 1'b0; mf_sel_e = 2'b00;
      forward_a_e = 2'b00; forward_b_e = 2'b00; alu_control_e = 3'b010;
      rd1_e = '0; rd2_e = '0; sign_imm_e = '0; result_w = '0; alu_out_m_fb = '0;
      rt_e = '0; rd_e = '0;
   endtask

   function automatic logic [2*WIDTH-1:0] md_model(input logic op, input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
      logic [2*WIDTH-1:0] aa, bb;
      aa = {{WIDTH{1'b0}}, a};
      bb = {{WIDTH{1'b0}}, b};
      if (!op) return aa * bb;
      if (b == '0) return {a, {WIDTH{1'b1}}};
      return {a % b, a / b};
   endfunction

   task automatic test_reset();
      idle_inputs();
      valid_e = 1'b1; rd1_e = 32'h1234; rd2_e = 32'h55; reg_dst_e = 1'b1; rd_e = 5'd7;
      rst_n = 1'b0;
      step();
      step();
      checks++;
      if ({valid_m, alu_out_m, write_data_m, write_reg_m} !== '0) begin
         failures++;
         $display("FAIL reset_m got v=%0b alu=%h wd=%h wr=%0d want all zero",
                  valid_m, alu_out_m, write_data_m, write_reg_m);
      end
      checks++;
      if (hi_o !== '0 || lo_o !== '0) begin
         failures++;
         $display("FAIL reset_hilo got hi=%h lo=%h want 0/0", hi_o, lo_o);
      end
      checks++;
      if (md_busy !== 1'b0 || stall_e !== 1'b0) begin
         failures++;
         $display("FAIL reset_busy got busy=%0b stall=%0b want 0/0", md_busy, stall_e);
      end
      rst_n = 1'b1;
      idle_inputs();
      step();
   endtask

   task automatic test_alu();
      row_t rows[10];
      m_t   e, got;
      rows[0] = '{1'b1, 3'b010, 2'b10, 2'b00, 1'b0, 1'b1, 32'h11, 32'h3, 32'h0, 32'h77, 32'h5,
                  5'd4, 5'd9, 32'h8, 32'h3, 5'd9};
      rows[1] = '{1'b1, 3'b111, 2'b00, 2'b00, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 32'h0,
                  5'd7, 5'd8, 32'h1, 32'h1, 5'd7};
      rows[2] = '{1'b1, 3'b110, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 32'h1, 32'h0, 32'h0, 32'h0,
                  5'd2, 5'd3, 32'hFFFF_FFFF, 32'h1, 5'd2};
      rows[3] = '{1'b1, 3'b011, 2'b00, 2'b00, 1'b0, 1'b0, 32'h5, 32'h6, 32'h0, 32'h0, 32'h0,
                  5'd3, 5'd4, 32'h0, 32'h6, 5'd3};
      rows[4] = '{1'b1, 3'b000, 2'b00, 2'b00, 1'b1, 1'b1, 32'hF0F0_1234, 32'hAAAA, 32'h0000_FF0F,
                  32'h0, 32'h0, 5'd1, 5'd31, 32'h0000_1204, 32'hAAAA, 5'd31};
      rows[5] = '{1'b1, 3'b001, 2'b01, 2'b10, 1'b0, 1'b0, 32'h1, 32'h2, 32'h0, 32'h0F00_0000,
                  32'hF0, 5'd1, 5'd6, 32'h0F00_00F0, 32'hF0, 5'd1};
      rows[6] = '{1'b1, 3'b010, 2'b11, 2'b11, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h2, 32'h0, 32'h9,
                  32'h9, 5'd0, 5'd5, 32'h1, 32'h2, 5'd5};
      rows[7] = '{1'b1, 3'b111, 2'b00, 2'b00, 1'b0, 1'b0, 32'h1, 32'hFFFF_FFFF, 32'h0, 32'h0,
                  32'h0, 5'd0, 5'd0, 32'h0, 32'hFFFF_FFFF, 5'd0};
      rows[8] = '{1'b1, 3'b100, 2'b00, 2'b01, 1'b1, 1'b0, 32'h3, 32'h3, 32'h7, 32'h9, 32'h0,
                  5'd10, 5'd11, 32'h0, 32'h9, 5'd10};
      rows[9] = '{1'b0, 3'b010, 2'b00, 2'b00, 1'b1, 1'b0, 32'h4, 32'h0, 32'h6, 32'h0, 32'h0,
                  5'd12, 5'd13, 32'hA, 32'h0, 5'd12};
      for (int i = 0; i < 10; i++) begin
         valid_e = rows[i].v; alu_control_e = rows[i].ctrl;
         forward_a_e = rows[i].fa; forward_b_e = rows[i].fb;
         alu_src_e = rows[i].asrc; reg_dst_e = rows[i].rdst;
         rd1_e = rows[i].rd1; rd2_e = rows[i].rd2; sign_imm_e = rows[i].imm;
         result_w = rows[i].resw; alu_out_m_fb = rows[i].mfb;
         rt_e = rows[i].rt; rd_e = rows[i].rd;
         exp_q.push_back({rows[i].v, rows[i].exp_alu, rows[i].exp_wd, rows[i].exp_wr});
         step();
         e   = exp_q.pop_front();
         got = {valid_m, alu_out_m, write_data_m, write_reg_m};
         checks++;
         if (got !== e) begin
            failures++;
            $display("FAIL alu_row%0d got v=%0b alu=%h wd=%h wr=%0d want v=%0b alu=%h wd=%h wr=%0d",
                     i, got.v, got.alu, got.wd, got.wr, e.v, e.alu, e.wd, e.wr);
         end
      end
      idle_inputs();
      step();
   endtask

   task automatic test_multu();
      m_t e, got;
      int n;
      idle_inputs();
      valid_e = 1'b1; md_start_e = 1'b1; md_op_e = 1'b0;
      rd1_e = 32'hFFFF_FFFF; rd2_e = 32'h2; reg_dst_e = 1'b1; rd_e = 5'd20;
      exp_q.push_back({1'b1, 32'h1, 32'h2, 5'd20});
      step();
      e   = exp_q.pop_front();
      got = {valid_m, alu_out_m, write_data_m, write_reg_m};
      checks++;
      if (got !== e) begin
         failures++;
         $display("FAIL multu_start_pass got v=%0b alu=%h want v=%0b alu=%h", got.v, got.alu, e.v, e.alu);
      end
      idle_inputs();
      #1;
      checks++;
      if (stall_e !== 1'b0 || md_busy !== 1'b1) begin
         failures++;
         $display("FAIL multu_no_valid_stall got stall=%0b busy=%0b want 0/1", stall_e, md_busy);
      end
      n = 0;
      while (md_busy === 1'b1 && n < 200) begin
         n++;
         if (n == WIDTH / 2) begin
            checks++;
            if (hi_o !== '0 || lo_o !== '0) begin
               failures++;
               $display("FAIL multu_hilo_mid got hi=%h lo=%h want 0/0", hi_o, lo_o);
            end
         end
         step();
      end
      checks++;
      if (n != WIDTH + 1) begin
         failures++;
         $display("FAIL multu_busy_len got %0d want %0d", n, WIDTH + 1);
      end
      checks++;
      if (hi_o !== 32'h1 || lo_o !== 32'hFFFF_FFFE) begin
         failures++;
         $display("FAIL multu_result got hi=%h lo=%h want 1/fffffffe", hi_o, lo_o);
      end
   endtask

   task automatic test_divu();
      logic [WIDTH-1:0] exp_lo[2], exp_hi[2], exp_pass[2], exp_wd[2];
      m_t e, got;
      int n;
      exp_lo[0] = 32'd14; exp_hi[0] = 32'd2;  exp_pass[0] = 32'd107; exp_wd[0] = 32'd7;
      exp_lo[1] = 32'hFFFF_FFFF; exp_hi[1] = 32'd9; exp_pass[1] = 32'd9; exp_wd[1] = 32'd0;
      idle_inputs();
      md_start_e = 1'b1; md_op_e = 1'b1; rd1_e = 32'd3; rd2_e = 32'd1;
      step();
      checks++;
      if (md_busy !== 1'b0) begin
         failures++;
         $display("FAIL divu_invalid_start got busy=%0b want 0", md_busy);
      end
      for (int i = 0; i < 2; i++) begin
         idle_inputs();
         valid_e = 1'b1; md_start_e = 1'b1; md_op_e = 1'b1; rt_e = 5'(i + 1);
         if (i == 0) begin
            forward_a_e = 2'b01; result_w = 32'd100; rd1_e = 32'd55; rd2_e = 32'd7;
         end else begin
            forward_b_e = 2'b10; alu_out_m_fb = 32'd0; rd1_e = 32'd9; rd2_e = 32'd5;
         end
         exp_q.push_back({1'b1, exp_pass[i], exp_wd[i], 5'(i + 1)});
         step();
         e   = exp_q.pop_front();
         got = {valid_m, alu_out_m, write_data_m, write_reg_m};
         checks++;
         if (got !== e) begin
            failures++;
            $display("FAIL divu%0d_start_pass got alu=%h wd=%h want alu=%h wd=%h",
                     i, got.alu, got.wd, e.alu, e.wd);
         end
         idle_inputs();
         n = 0;
         while (md_busy === 1'b1 && n < 200) begin
            n++;
            step();
         end
         checks++;
         if (n != WIDTH + 1 || lo_o !== exp_lo[i] || hi_o !== exp_hi[i]) begin
            failures++;
            $display("FAIL divu%0d_result got lat=%0d lo=%h hi=%h want lat=%0d lo=%h hi=%h",
                     i, n, lo_o, hi_o, WIDTH + 1, exp_lo[i], exp_hi[i]);
         end
      end
   endtask

   task automatic test_mflo_stall();
      logic [2*WIDTH-1:0] r;
      m_t e, got;
      int n, bad;
      r = md_model(1'b0, 32'h0001_0003, 32'h0002_0005);
      idle_inputs();
      valid_e = 1'b1; md_start_e = 1'b1; rd1_e = 32'h0001_0003; rd2_e = 32'h0002_0005;
      step();
      idle_inputs();
      step();
      valid_e = 1'b1; mf_sel_e = 2'b10; rd2_e = 32'h55; reg_dst_e = 1'b1; rd_e = 5'd12;
      #1;
      n = 0;
      bad = 0;
      while (stall_e === 1'b1 && n < 200) begin
         n++;
         step();
         if (valid_m !== 1'b0) bad++;
      end
      checks++;
      if (n != WIDTH) begin
         failures++;
         $display("FAIL mflo_stall_len got %0d want %0d", n, WIDTH);
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL mflo_bubble got %0d non-bubble cycles want 0", bad);
      end
      exp_q.push_back({1'b1, r[WIDTH-1:0], 32'h55, 5'd12});
      step();
      e   = exp_q.pop_front();
      got = {valid_m, alu_out_m, write_data_m, write_reg_m};
      checks++;
      if (got !== e || hi_o !== r[2*WIDTH-1:WIDTH]) begin
         failures++;
         $display("FAIL mflo_result got v=%0b alu=%h hi=%h want v=%0b alu=%h hi=%h",
                  got.v, got.alu, hi_o, e.v, e.alu, r[2*WIDTH-1:WIDTH]);
      end
      idle_inputs();
   endtask

   task automatic test_back_to_back();
      logic [2*WIDTH-1:0] r1, r2;
      m_t e, got;
      int n;
      r1 = md_model(1'b0, 32'd3, 32'd5);
      r2 = md_model(1'b1, 32'hFFFF_FFFF, 32'h10);
      idle_inputs();
      valid_e = 1'b1; md_start_e = 1'b1; rd1_e = 32'd3; rd2_e = 32'd5;
      step();
      md_op_e = 1'b1; rd1_e = 32'hFFFF_FFFF; rd2_e = 32'h10; rt_e = 5'd17;
      #1;
      n = 0;
      while (stall_e === 1'b1 && n < 200) begin
         n++;
         step();
      end
      checks++;
      if (n != WIDTH + 1 || hi_o !== r1[2*WIDTH-1:WIDTH] || lo_o !== r1[WIDTH-1:0]) begin
         failures++;
         $display("FAIL b2b_first got stall=%0d hi=%h lo=%h want stall=%0d hi=%h lo=%h",
                  n, hi_o, lo_o, WIDTH + 1, r1[2*WIDTH-1:WIDTH], r1[WIDTH-1:0]);
      end
      exp_q.push_back({1'b1, 32'hF, 32'h10, 5'd17});
      step();
      e   = exp_q.pop_front();
      got = {valid_m, alu_out_m, write_data_m, write_reg_m};
      checks++;
      if (got !== e || md_busy !== 1'b1) begin
         failures++;
         $display("FAIL b2b_second_issue got v=%0b alu=%h busy=%0b want v=%0b alu=%h busy=1",
                  got.v, got.alu, md_busy, e.v, e.alu);
      end
      idle_inputs();
      n = 0;
      while (md_busy === 1'b1 && n < 200) begin
         n++;
         step();
      end
      checks++;
      if (hi_o !== r2[2*WIDTH-1:WIDTH] || lo_o !== r2[WIDTH-1:0]) begin
         failures++;
         $display("FAIL b2b_second_result got hi=%h lo=%h want hi=%h lo=%h",
                  hi_o, lo_o, r2[2*WIDTH-1:WIDTH], r2[WIDTH-1:0]);
      end
   endtask

   task automatic test_reset_midop();
      logic [2*WIDTH-1:0] r;
      m_t e, got;
      int n;
      r = md_model(1'b1, 32'd50, 32'd5);
      idle_inputs();
      valid_e = 1'b1; md_start_e = 1'b1; rd1_e = 32'd7; rd2_e = 32'd9;
      step();
      idle_inputs();
      repeat (10) step();
      rst_n = 1'b0; valid_e = 1'b1; mf_sel_e = 2'b10;
      step();
      checks++;
      if (md_busy !== 1'b0 || valid_m !== 1'b0 || stall_e !== 1'b0) begin
         failures++;
         $display("FAIL midreset_state got busy=%0b valid_m=%0b stall=%0b want 0/0/0",
                  md_busy, valid_m, stall_e);
      end
      checks++;
      if (hi_o !== '0 || lo_o !== '0) begin
         failures++;
         $display("FAIL midreset_hilo got hi=%h lo=%h want 0/0", hi_o, lo_o);
      end
      rst_n = 1'b1;
      idle_inputs();
      valid_e = 1'b1; md_start_e = 1'b1; md_op_e = 1'b1; rd1_e = 32'd50; rd2_e = 32'd5; rt_e = 5'd3;
      exp_q.push_back({1'b1, 32'd55, 32'd5, 5'd3});
      step();
      e   = exp_q.pop_front();
      got = {valid_m, alu_out_m, write_data_m, write_reg_m};
      checks++;
      if (got !== e || md_busy !== 1'b1) begin
         failures++;
         $display("FAIL midreset_restart got v=%0b alu=%h busy=%0b want v=%0b alu=%h busy=1",
                  got.v, got.alu, md_busy, e.v, e.alu);
      end
      idle_inputs();
      n = 0;
      while (md_busy === 1'b1 && n < 200) begin
         n++;
         step();
      end
      checks++;
      if (lo_o !== r[WIDTH-1:0] || hi_o !== r[2*WIDTH-1:WIDTH]) begin
         failures++;
         $display("FAIL midreset_result got lo=%h hi=%h want lo=%h hi=%h",
                  lo_o, hi_o, r[WIDTH-1:0], r[2*WIDTH-1:WIDTH]);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      idle_inputs();
      test_reset();
      test_alu();
      test_multu();
      test_divu();
      test_mflo_stall();
      test_back_to_back();
      test_reset_midop();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/execute_stage_md.md
# execute_stage_md

Parametrised execute stage for the MiniMIPS pipeline, successor to the combinational execute block. It keeps forwarding, the ALU and write-register selection, and adds three things. First, an owned E/M pipeline register. Second, an iterative unsigned multiply/divide unit with HI/LO registers. Third, HI/LO move instructions, with a stall output while the multiply/divide unit is busy. It sits between the ID/EX register and the memory stage; the hazard unit consumes `stall_e`.

## Interface
- `WIDTH`, 32: datapath width (≥8).
- `REGW`, 5: register-index width.
- `clk  in  1`: rising-edge clock.
- `rst_n  in  1`: synchronous reset, active low.
- `valid_e  in  1`: instruction present in E.
- `alu_src_e  in  1`: 1 selects `sign_imm_e` as SrcB.
- `reg_dst_e  in  1`: 1 selects `rd_e`, 0 selects `rt_e`.
- `forward_a_e, forward_b_e  in  2`: 00 = register value, 01 = `result_w`, 10 = `alu_out_m`, 11 = register value.
- `alu_control_e  in  3`: 000 AND, 010 ADD, 110 SUB, 111 SLT (signed), 001 OR; any other code gives 0.
- `md_start_e  in  1`: start a multiply/divide.
- `md_op_e  in  1`: 0 = MULTU, 1 = DIVU.
- `mf_sel_e  in  2`: 00 = ALU result, 01 = HI, 10 = LO, 11 = ALU result.
- `rd1_e, rd2_e, sign_imm_e, result_w, alu_out_m_fb  in  WIDTH`: operands and forward sources.
- `rt_e, rd_e  in  REGW`: destination candidates.
- `valid_m  out  1`; `alu_out_m, write_data_m  out  WIDTH`; `write_reg_m  out  REGW`: E/M register outputs.
- `hi_o, lo_o  out  WIDTH`: architectural HI/LO.
- `md_busy  out  1`: multiply/divide unit not idle.
- `stall_e  out  1`: hold stages F/D/E this cycle.

## Operation
- SrcA is the forward-A mux output. The forwarded B value goes to `write_data_m`. SrcB is the immediate if `alu_src_e` is 1, otherwise the forwarded B value.
- ADD and SUB wrap modulo 2^WIDTH. SLT produces 1 or 0, zero-extended.
- E result is the ALU output, HI or LO, as chosen by `mf_sel_e`.
- `stall_e` = `valid_e & md_busy & (md_start_e | mf_sel_e==01 | mf_sel_e==10)`.
- E/M register, on each edge:
  - If `stall_e` is 1: `valid_m` ← 0 (bubble); all other M fields hold.
  - Otherwise: `valid_m` ← `valid_e`, and all M fields load from E.
- Multiply/divide FSM has three states: IDLE, RUN, DONE.
  - IDLE: on `valid_e & md_start_e & !stall_e`, latch the forwarded operands and `md_op_e`, clear the counter, go to RUN.
  - RUN: perform one iteration per cycle. MULTU uses shift-add on a 2·WIDTH accumulator. DIVU uses restoring division (shift, trial subtract). After iteration WIDTH−1, go to DONE.
  - DONE: write HI/LO, go to IDLE.
- MULTU result: HI:LO = A×B, full 2·WIDTH bits.
- DIVU result: LO = quotient, HI = remainder. Divide by zero gives LO = all ones, HI = dividend, with the same latency.
- HI/LO change only in DONE.
- The start instruction itself passes to M normally.
- `md_busy` = (state ≠ IDLE).

## Timing
- ALU path latency: E inputs at edge k appear on the M outputs after edge k.
- Multiply/divide latency: start accepted at edge N; RUN edges N+1…N+WIDTH; DONE at edge N+WIDTH+1.
  - HI/LO are valid after that DONE edge.
  - `md_busy` drops in the same cycle.
- A stalled MFHI/MFLO or second start proceeds in the first cycle with `md_busy` = 0. It is never issued while `md_busy` is 1.
- Reset takes effect at any edge with `rst_n` = 0, including mid-operation (the operation is aborted). After reset:
  - state is IDLE and the counter is 0;
  - `hi_o`, `lo_o`, `alu_out_m`, `write_data_m`, `write_reg_m` are 0;
  - `valid_m`, `md_busy`, `stall_e` are 0.
- Start with `valid_e` = 0 is ignored.

## Structure
- Package `exec_pkg` holds:
  - ALU opcode constants;
  - forward-select constants;
  - `md_op` and `mf_sel` constants;
  - the FSM state enum.
- Sub-module `md_unit` holds the FSM, counter, iterative datapath and HI/LO registers.
- The top level holds the forwarding muxes, ALU, result mux, stall logic and E/M register.

## Test plan
- ADD, `forward_a_e`=10, `alu_out_m_fb`=5, `rd2_e`=3 → after 1 edge: `alu_out_m`=8, `valid_m`=1.
- SLT: A=0xFFFFFFFF, B=1 → 1. SUB: 0−1 → 0xFFFFFFFF. Code 011 → 0.
- MULTU 0xFFFFFFFF×2 → after 33 edges: HI=1, LO=0xFFFFFFFE; `md_busy` high for exactly 33 cycles.
- DIVU 100/7 → LO=14, HI=2. DIVU 9/0 → LO=0xFFFFFFFF, HI=9.
- MFLO issued the cycle after start → `stall_e` high for 32 cycles, bubble `valid_m`=0 each stalled cycle, then `alu_out_m` = new LO.
- `rst_n` low at RUN iteration 10 → next cycle `md_busy`=0, HI=LO=0, `valid_m`=0; a new start is accepted immediately.
